// File: rtl/rfphoenix_vec_alu_seq_pkg.sv
// Shared types for the rfPhoenix sequenced vector ALU: states, opcodes,
// function codes and the cross-lane / compare classifiers.
package rfphoenix_vec_alu_seq_pkg;

    localparam int ASIDW = 10;
    localparam logic [31:0] PTE_NOMATCH = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef enum logic [6:0] {
        OP_R2    = 7'h02,
        OP_ADDI  = 7'h04,
        OP_CMPI  = 7'h06,
        OP_CMPUI = 7'h07
    } opcode_t;

    typedef struct packed {
        logic [5:0] func;
        opcode_t    opcode;
    } instr_t;

    localparam logic [5:0] F_ADD      = 6'd0;
    localparam logic [5:0] F_SUB      = 6'd1;
    localparam logic [5:0] F_AND      = 6'd2;
    localparam logic [5:0] F_OR       = 6'd3;
    localparam logic [5:0] F_XOR      = 6'd4;
    localparam logic [5:0] F_SLL      = 6'd5;
    localparam logic [5:0] F_SRL      = 6'd6;
    localparam logic [5:0] F_CMOV     = 6'd7;
    localparam logic [5:0] F_HASH     = 6'd8;
    localparam logic [5:0] F_CMP_EQ   = 6'd16;
    localparam logic [5:0] F_CMP_LT   = 6'd17;
    localparam logic [5:0] F_CMP_LTU  = 6'd18;
    localparam logic [5:0] F_FCMP_EQ  = 6'd20;
    localparam logic [5:0] F_FCMP_LT  = 6'd21;
    // cross-lane functions
    localparam logic [5:0] F_VEX      = 6'd32;
    localparam logic [5:0] F_VSHUF    = 6'd33;
    localparam logic [5:0] F_VSLLV    = 6'd34;
    localparam logic [5:0] F_VSRLV    = 6'd35;
    localparam logic [5:0] F_VSLLVI   = 6'd36;
    localparam logic [5:0] F_VSRLVI   = 6'd37;
    localparam logic [5:0] F_SHPTENDX = 6'd38;

    function automatic logic is_xlane(instr_t i);
        return i.opcode == OP_R2 &&
            i.func inside {F_VEX, F_VSHUF, F_VSLLV, F_VSRLV,
                           F_VSLLVI, F_VSRLVI, F_SHPTENDX};
    endfunction

    function automatic logic is_cmp(instr_t i);
        return i.opcode inside {OP_CMPI, OP_CMPUI} ||
            (i.opcode == OP_R2 &&
             i.func inside {F_CMP_EQ, F_CMP_LT, F_CMP_LTU,
                            F_FCMP_EQ, F_FCMP_LT});
    endfunction

endpackage

// File: rtl/rfphoenix_vec_alu_seq_if.sv
// Request/result handshake bundle for the sequenced vector ALU.
interface rfphoenix_vec_alu_seq_if
    import rfphoenix_vec_alu_seq_pkg::*;
#(
    parameter int NLANES = 16,
    parameter int WID    = 32
);
    logic                         req;
    logic                         rdy;
    instr_t                       ir;
    logic [NLANES-1:0][WID-1:0]   a;
    logic [NLANES-1:0][WID-1:0]   b;
    logic [NLANES-1:0][WID-1:0]   c;
    logic [NLANES-1:0][WID-1:0]   d;
    logic [NLANES-1:0]            vmask;
    logic                         Tt;
    logic [WID-1:0]               imm;
    logic [ASIDW-1:0]             asid;
    logic [WID-1:0]               hmask;
    logic [NLANES-1:0][WID-1:0]   o;
    logic                         o_valid;
    logic                         o_ready;

    modport master (
        output req, ir, a, b, c, d, vmask, Tt, imm, asid, hmask, o_ready,
        input  rdy, o, o_valid
    );

    modport slave (
        input  req, ir, a, b, c, d, vmask, Tt, imm, asid, hmask, o_ready,
        output rdy, o, o_valid
    );
endinterface

// File: rtl/rfphoenix_vec_alu_seq_slice.sv
// Scalar lane ALU plus an LPC-wide slice with optional lane-mask merge.
// Merge muxes exist only when RFPHOENIX_VEC_MASK_EN is defined.
module rfphoenix_alu
    import rfphoenix_vec_alu_seq_pkg::*;
#(
    parameter int WID = 32
) (
    input  instr_t           ir,
    input  logic [WID-1:0]   a,
    input  logic [WID-1:0]   b,
    input  logic [WID-1:0]   c,
    input  logic [WID-1:0]   imm,
    input  logic [ASIDW-1:0] asid,
    input  logic [WID-1:0]   hmask,
    output logic [WID-1:0]   o
);
    localparam int SW = $clog2(WID);

    function automatic logic flt(logic [WID-1:0] x, logic [WID-1:0] y);
        if (x[WID-2:0] == '0 && y[WID-2:0] == '0) return 1'b0;
        if (x[WID-1] != y[WID-1]) return x[WID-1];
        return x[WID-1] ? (x[WID-2:0] > y[WID-2:0])
                        : (x[WID-2:0] < y[WID-2:0]);
    endfunction

    function automatic logic feq(logic [WID-1:0] x, logic [WID-1:0] y);
        return (x == y) || (x[WID-2:0] == '0 && y[WID-2:0] == '0);
    endfunction

    always_comb begin
        o = '0;
        case (ir.opcode)
            OP_ADDI:  o = a + imm;
            OP_CMPI:  o = WID'($signed(a) < $signed(imm));
            OP_CMPUI: o = WID'(a < imm);
            OP_R2: begin
                case (ir.func)
                    F_ADD:     o = a + b;
                    F_SUB:     o = a - b;
                    F_AND:     o = a & b;
                    F_OR:      o = a | b;
                    F_XOR:     o = a ^ b;
                    F_SLL:     o = a << b[SW-1:0];
                    F_SRL:     o = a >> b[SW-1:0];
                    F_CMOV:    o = (c != '0) ? a : b;
                    F_HASH:    o = (a ^ b ^ {asid, {(WID-ASIDW){1'b0}}}) & hmask;
                    F_CMP_EQ:  o = WID'(a == b);
                    F_CMP_LT:  o = WID'($signed(a) < $signed(b));
                    F_CMP_LTU: o = WID'(a < b);
                    F_FCMP_EQ: o = WID'(feq(a, b));
                    F_FCMP_LT: o = WID'(flt(a, b));
                    default:   o = '0;
                endcase
            end
            default: o = '0;
        endcase
    end
endmodule

module rfphoenix_vec_alu_slice
    import rfphoenix_vec_alu_seq_pkg::*;
#(
    parameter int LPC = 4,
    parameter int WID = 32
) (
    input  instr_t                  ir,
`ifdef RFPHOENIX_VEC_MASK_EN
    input  logic [LPC-1:0]          en,
    input  logic [LPC-1:0][WID-1:0] d,
`endif
    input  logic [LPC-1:0][WID-1:0] a,
    input  logic [LPC-1:0][WID-1:0] b,
    input  logic [LPC-1:0][WID-1:0] c,
    input  logic [WID-1:0]          imm,
    input  logic [ASIDW-1:0]        asid,
    input  logic [WID-1:0]          hmask,
    output logic [LPC-1:0][WID-1:0] res,
    output logic [LPC-1:0]          bits
);
    logic [LPC-1:0][WID-1:0] r;

    for (genvar i = 0; i < LPC; i++) begin : g_alu
        rfphoenix_alu #(.WID(WID)) u_alu (
            .ir    (ir),
            .a     (a[i]),
            .b     (b[i]),
            .c     (c[i]),
            .imm   (imm),
            .asid  (asid),
            .hmask (hmask),
            .o     (r[i])
        );
    end

    always_comb begin
        res  = r;
        bits = '0;
        for (int i = 0; i < LPC; i++) begin
`ifdef RFPHOENIX_VEC_MASK_EN
            res[i]  = en[i] ? r[i] : d[i];
            bits[i] = en[i] & r[i][0];
`else
            bits[i] = r[i][0];
`endif
        end
    end
endmodule

// File: rtl/rfphoenix_vec_alu_seq.sv
// Sequenced vector ALU: LPC lanes per cycle, single-cycle cross-lane ops.
// Lane masking is built only when RFPHOENIX_VEC_MASK_EN is defined.
module rfphoenix_vec_alu_seq
    import rfphoenix_vec_alu_seq_pkg::*;
#(
    parameter int NLANES = 16,
    parameter int LPC    = 4,
    parameter int WID    = 32
) (
    input logic                    rst,
    input logic                    clk,
    rfphoenix_vec_alu_seq_if.slave bus
);
    localparam int NGRP = NLANES / LPC;
    localparam int GW   = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam int LW   = $clog2(NLANES);

    state_t state_q, state_d;
    logic [GW-1:0] grp_q;
    instr_t ir_q;
    logic [NLANES-1:0][WID-1:0] a_q, b_q, c_q, res_q;
    logic [WID-1:0] imm_q, hmask_q;
    logic [ASIDW-1:0] asid_q;
    logic tt_q;
`ifdef RFPHOENIX_VEC_MASK_EN
    logic [NLANES-1:0][WID-1:0] d_q;
    logic [NLANES-1:0] vm_q;
    logic [LPC-1:0][WID-1:0] ld;
    logic [LPC-1:0] lm;
`endif

    logic [LPC-1:0][WID-1:0] la, lb, lc, sres;
    logic [LPC-1:0] sbits;
    logic [NLANES-1:0][WID-1:0] xres;
    logic [WID-1:0] pv;
    logic [LW-1:0] sh;
    logic xlane, packed_cmp, last;

    assign xlane      = is_xlane(ir_q);
    assign packed_cmp = is_cmp(ir_q) && !tt_q;
    assign last       = (grp_q == GW'(NGRP - 1));

    assign bus.rdy     = (state_q == IDLE);
    assign bus.o_valid = (state_q == DONE);
    assign bus.o       = res_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.req) state_d = RUN;
            RUN:     if (xlane || last) state_d = DONE;
            DONE:    if (bus.o_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        la = '0;
        lb = '0;
        lc = '0;
`ifdef RFPHOENIX_VEC_MASK_EN
        ld = '0;
        lm = '0;
`endif
        for (int i = 0; i < LPC; i++) begin
            la[i] = a_q[int'(grp_q) * LPC + i];
            lb[i] = b_q[int'(grp_q) * LPC + i];
            lc[i] = c_q[int'(grp_q) * LPC + i];
`ifdef RFPHOENIX_VEC_MASK_EN
            ld[i] = d_q[int'(grp_q) * LPC + i];
            lm[i] = vm_q[int'(grp_q) * LPC + i];
`endif
        end
    end

    rfphoenix_vec_alu_slice #(.LPC(LPC), .WID(WID)) u_slice (
        .ir    (ir_q),
`ifdef RFPHOENIX_VEC_MASK_EN
        .en    (lm),
        .d     (ld),
`endif
        .a     (la),
        .b     (lb),
        .c     (lc),
        .imm   (imm_q),
        .asid  (asid_q),
        .hmask (hmask_q),
        .res   (sres),
        .bits  (sbits)
    );

    // Cross-lane unit sees the whole latched vector at once.
    always_comb begin
        xres = '0;
        pv   = WID'(PTE_NOMATCH);
        sh   = ir_q.func inside {F_VSLLVI, F_VSRLVI} ? imm_q[LW-1:0]
                                                    : b_q[0][LW-1:0];
        for (int k = 0; k < NLANES / 2; k++) begin
            if (a_q[0][31:16] == b_q[2*k+1][15:0] &&
                (asid_q == b_q[2*k+1][31:22] || b_q[2*k+1][21]))
                pv = WID'(k);
        end
        for (int n = 0; n < NLANES; n++) begin
            case (ir_q.func)
                F_VEX:   xres[n] = a_q[imm_q[LW-1:0]];
                F_VSHUF: xres[n] = a_q[b_q[n][LW-1:0]];
                F_VSLLV, F_VSLLVI:
                    if (n >= int'(sh)) xres[n] = a_q[n - int'(sh)];
                F_VSRLV, F_VSRLVI:
                    if (n + int'(sh) < NLANES) xres[n] = a_q[n + int'(sh)];
                F_SHPTENDX: xres[n] = pv;
                default: xres[n] = '0;
            endcase
`ifdef RFPHOENIX_VEC_MASK_EN
            if (!vm_q[n]) xres[n] = d_q[n];
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grp_q   <= '0;
            res_q   <= '0;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            imm_q   <= '0;
            hmask_q <= '0;
            asid_q  <= '0;
            tt_q    <= 1'b0;
`ifdef RFPHOENIX_VEC_MASK_EN
            d_q     <= '0;
            vm_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && bus.req) begin
                ir_q    <= bus.ir;
                a_q     <= bus.a;
                b_q     <= bus.b;
                c_q     <= bus.c;
                imm_q   <= bus.imm;
                hmask_q <= bus.hmask;
                asid_q  <= bus.asid;
                tt_q    <= bus.Tt;
`ifdef RFPHOENIX_VEC_MASK_EN
                d_q     <= bus.d;
                vm_q    <= bus.vmask;
`endif
                grp_q   <= '0;
                res_q   <= '0;
            end else if (state_q == RUN) begin
                grp_q <= grp_q + 1'b1;
                if (xlane) begin
                    res_q <= xres;
                end else if (packed_cmp) begin
                    // packed bits beyond the lane width are dropped
                    for (int i = 0; i < LPC; i++)
                        if (int'(grp_q) * LPC + i < WID)
                            res_q[0][int'(grp_q) * LPC + i] <= sbits[i];
                end else begin
                    for (int i = 0; i < LPC; i++)
                        res_q[int'(grp_q) * LPC + i] <= sres[i];
                end
            end
        end
    end
endmodule
